// File: rtl/timer_arbiter.sv
// Round-robin arbiter for three requesters sharing a single tick-based down-counter timer.
// The prescaler free-runs from reset; the FSM grants, times, and pulses done or aborts.
module timer_arbiter #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned DUR_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [DUR_W-1:0] dur0,
  input  logic [DUR_W-1:0] dur1,
  input  logic [DUR_W-1:0] dur2,
  output logic [2:0]       gnt,
  output logic [2:0]       done,
  output logic             busy,
  output logic             tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       state, state_nxt;
  logic [DUR_W-1:0] rem, rem_nxt;
  logic [1:0]       last, last_nxt;
  logic [1:0]       cur, cur_nxt;
  logic [2:0]       gnt_nxt, done_nxt;
  logic             busy_nxt;
  logic [1:0]       pick;
  logic             pick_vld;
  logic [DUR_W-1:0] sel_dur;

  // Prescaler: tick is registered so it is high exactly while cnt == DIV-1.
  always_comb begin
    cnt_nxt = (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CNT_W'(DIV - 1));
    end
  end

  // Round-robin search starting just after the last served index.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b1;
    case (last)
      2'd0: begin
        if (req[1])      pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else             pick_vld = 1'b0;
      end
      2'd1: begin
        if (req[2])      pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else             pick_vld = 1'b0;
      end
      default: begin
        if (req[0])      pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else             pick_vld = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (pick)
      2'd0:    sel_dur = dur0;
      2'd1:    sel_dur = dur1;
      default: sel_dur = dur2;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    done_nxt  = 3'b000;
    busy_nxt  = busy;
    rem_nxt   = rem;
    last_nxt  = last;
    cur_nxt   = cur;
    case (state)
      S_IDLE: begin
        gnt_nxt  = 3'b000;
        busy_nxt = 1'b0;
        if (pick_vld) begin
          state_nxt = S_RUN;
          gnt_nxt   = 3'b001 << pick;
          rem_nxt   = sel_dur;
          cur_nxt   = pick;
          busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (!req[cur]) begin
          state_nxt = S_IDLE;
          gnt_nxt   = 3'b000;
          busy_nxt  = 1'b0;
          last_nxt  = cur;
        end else if (rem == '0) begin
          state_nxt = S_DONE;
          gnt_nxt   = 3'b000;
          done_nxt  = gnt;
          last_nxt  = cur;
        end else if (tick) begin
          rem_nxt = rem - DUR_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        gnt_nxt   = 3'b000;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        gnt_nxt   = 3'b000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      gnt   <= 3'b000;
      done  <= 3'b000;
      busy  <= 1'b0;
      rem   <= '0;
      last  <= 2'd2;
      cur   <= 2'd0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
      rem   <= rem_nxt;
      last  <= last_nxt;
      cur   <= cur_nxt;
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized and directed bench for timer_arbiter against a transaction-level reference model.
module tb_timer_arbiter;

  localparam int unsigned DIV   = 10;
  localparam int unsigned DUR_W = 8;

  logic             clk;
  logic             rst;
  logic [2:0]       req;
  logic [DUR_W-1:0] dur0, dur1, dur2;
  logic [2:0]       gnt, done;
  logic             busy, tick;

  int errors = 0;
  int checks = 0;

  timer_arbiter #(.CLK_HZ(10), .TICK_HZ(1), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .dur0(dur0), .dur1(dur1), .dur2(dur2),
    .gnt(gnt), .done(done), .busy(busy), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one served requester at a time, counted in ticks.
  int         m_edges;
  bit         m_active, m_finishing;
  int         m_serving, m_left, m_last;
  logic [2:0] m_gnt, m_done;

  task automatic model_reset();
    m_edges = 0; m_active = 0; m_finishing = 0;
    m_serving = 0; m_left = 0; m_last = 2;
    m_gnt = 3'b000; m_done = 3'b000;
  endtask

  function automatic bit model_tick();
    return (m_edges % DIV) == (DIV - 1);
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_gnt, m_done, logic'(m_active || m_finishing), logic'(model_tick())};
  endfunction

  function automatic int rr_pick(input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic cycle();
    logic [2:0] r;
    int d[3];
    bit t;
    int p;
    @(posedge clk);
    r = req;
    d[0] = int'(dur0); d[1] = int'(dur1); d[2] = int'(dur2);
    t = model_tick();
    m_done = 3'b000;
    if (m_finishing) begin
      m_finishing = 0;
    end else if (m_active) begin
      if (!r[m_serving]) begin
        m_active = 0; m_gnt = 3'b000; m_last = m_serving;
      end else if (m_left == 0) begin
        m_active = 0; m_finishing = 1; m_gnt = 3'b000;
        m_done = 3'(1 << m_serving); m_last = m_serving;
      end else if (t) begin
        m_left = m_left - 1;
      end
    end else begin
      p = rr_pick(r);
      if (p >= 0) begin
        m_active = 1; m_serving = p; m_left = d[p]; m_gnt = 3'(1 << p);
      end
    end
    m_edges++;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    int ticks;
    rst = 1'b1; req = 3'b000; dur0 = '0; dur1 = '0; dur2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, done, busy, tick} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b done=%b busy=%b tick=%b want all 0", gnt, done, busy, tick);
    end
    rst = 1'b0;
    ticks = 0;
    for (int c = 0; c < 25; c++) begin
      cycle();
      if (tick === 1'b1) ticks++;
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle c=%0d got %b want %b", c, {gnt, done, busy, tick}, exp_vec());
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL tick_period got %0d ticks want 2", ticks);
    end
  endtask

  task automatic test_single();
    int ticks, c;
    bit saw;
    apply_reset();
    dur0 = 8'd3; req = 3'b001;
    ticks = 0; saw = 0;
    cycle();
    checks++;
    if (gnt !== 3'b001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got gnt=%b busy=%b want 001/1", gnt, busy);
    end
    for (c = 0; c < 100 && !saw; c++) begin
      if (gnt === 3'b001 && tick === 1'b1) ticks++;
      cycle();
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL single_cycle c=%0d got %b want %b", c, {gnt, done, busy, tick}, exp_vec());
      end
      if (done === 3'b001) begin
        saw = 1;
        checks++;
        if (gnt !== 3'b000) begin
          errors++;
          $display("FAIL single_gnt_at_done got %b want 000", gnt);
        end
      end
    end
    checks++;
    if (!saw || ticks != 3) begin
      errors++;
      $display("FAIL single_done saw=%0d ticks=%0d want 1/3", saw, ticks);
    end
    req = 3'b000;
    repeat (2) begin
      cycle();
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL single_idle got %b want %b", {gnt, done, busy, tick}, exp_vec());
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int want[6] = '{0, 1, 2, 0, 1, 2};
    bit second;
    apply_reset();
    dur0 = 8'($urandom_range(0, 3)); dur1 = 8'($urandom_range(0, 3)); dur2 = 8'($urandom_range(0, 3));
    req = 3'b111; second = 0;
    for (int c = 0; c < 1000 && order.size() < 6; c++) begin
      cycle();
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec() || $countones(gnt) > 1) begin
        errors++;
        $display("FAIL rr_cycle c=%0d got %b want %b", c, {gnt, done, busy, tick}, exp_vec());
      end
      if (done !== 3'b000) begin
        for (int i = 0; i < 3; i++) if (done[i] === 1'b1) order.push_back(i);
        req = req & ~done;
        if (req == 3'b000 && !second) begin
          second = 1; req = 3'b111;
          dur0 = 8'($urandom_range(0, 3)); dur1 = 8'($urandom_range(0, 3)); dur2 = 8'($urandom_range(0, 3));
        end
      end
    end
    checks++;
    if (order.size() != 6) begin
      errors++;
      $display("FAIL rr_count got %0d dones want 6", order.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (order[i] != want[i]) begin
          errors++;
          $display("FAIL rr_order i=%0d got %0d want %0d", i, order[i], want[i]);
        end
      end
    end
    req = 3'b000;
    repeat (3) cycle();
  endtask

  task automatic test_zero_dur();
    dur1 = 8'd0; dur0 = 8'($urandom); dur2 = 8'($urandom);
    req = 3'b010;
    cycle();
    checks++;
    if (gnt !== 3'b010 || done !== 3'b000 || {gnt, done, busy, tick} !== exp_vec()) begin
      errors++;
      $display("FAIL zero_grant got gnt=%b done=%b want 010/000", gnt, done);
    end
    cycle();
    checks++;
    if (done !== 3'b010 || gnt !== 3'b000 || {gnt, done, busy, tick} !== exp_vec()) begin
      errors++;
      $display("FAIL zero_done got gnt=%b done=%b want 000/010", gnt, done);
    end
    req = 3'b000;
    repeat (2) cycle();
  endtask

  task automatic test_abort();
    int ticks, c;
    bit dropped;
    apply_reset();
    dur0 = 8'd5; dur1 = 8'd1; req = 3'b011;
    ticks = 0; dropped = 0;
    for (c = 0; c < 200 && !dropped; c++) begin
      cycle();
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL abort_run c=%0d got %b want %b", c, {gnt, done, busy, tick}, exp_vec());
      end
      if (gnt === 3'b001 && tick === 1'b1) ticks++;
      if (ticks == 2) begin
        req = 3'b010; dropped = 1;
      end
    end
    cycle();
    checks++;
    if (gnt !== 3'b000 || done !== 3'b000) begin
      errors++;
      $display("FAIL abort_clear got gnt=%b done=%b want 000/000", gnt, done);
    end
    cycle();
    checks++;
    if (gnt !== 3'b010 || done !== 3'b000) begin
      errors++;
      $display("FAIL abort_regrant got gnt=%b done=%b want 010/000", gnt, done);
    end
    for (c = 0; c < 100 && req != 3'b000; c++) begin
      cycle();
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec() || done[0] === 1'b1) begin
        errors++;
        $display("FAIL abort_tail c=%0d got %b want %b", c, {gnt, done, busy, tick}, exp_vec());
      end
      if (done !== 3'b000) req = 3'b000;
    end
    repeat (2) cycle();
  endtask

  task automatic test_abort_at_zero();
    bit hit;
    apply_reset();
    dur0 = 8'd2; req = 3'b001; hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      cycle();
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL zabort_run c=%0d got %b want %b", c, {gnt, done, busy, tick}, exp_vec());
      end
      if (m_active && m_left == 0) begin
        req = 3'b000; hit = 1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL zabort_reach got 0 want 1");
    end
    repeat (2) begin
      cycle();
      checks++;
      if (done !== 3'b000 || gnt !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zabort_nodone got gnt=%b done=%b busy=%b want 000/000/0", gnt, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int ticks, c;
    bit saw;
    apply_reset();
    dur0 = 8'd8; req = 3'b001; ticks = 0;
    for (c = 0; c < 200 && ticks < 4; c++) begin
      cycle();
      if (gnt === 3'b001 && tick === 1'b1) ticks++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, done, busy, tick} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got gnt=%b done=%b busy=%b tick=%b want all 0", gnt, done, busy, tick);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL rst_regrant got %b want 001", gnt);
    end
    ticks = 0; saw = 0;
    for (c = 0; c < 200 && !saw; c++) begin
      if (gnt === 3'b001 && tick === 1'b1) ticks++;
      cycle();
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL rst_run c=%0d got %b want %b", c, {gnt, done, busy, tick}, exp_vec());
      end
      if (done === 3'b001) saw = 1;
    end
    checks++;
    if (!saw || ticks != 8) begin
      errors++;
      $display("FAIL rst_reload saw=%0d ticks=%0d want 1/8", saw, ticks);
    end
    req = 3'b000;
    repeat (2) cycle();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        dur0 = 8'($urandom_range(0, 6));
        dur1 = 8'($urandom_range(0, 6));
        dur2 = 8'($urandom_range(0, 6));
      end
      cycle();
      checks++;
      if ({gnt, done, busy, tick} !== exp_vec() || $countones(gnt) > 1 || $countones(done) > 1) begin
        errors++;
        $display("FAIL random c=%0d req=%b got %b want %b", c, req, {gnt, done, busy, tick}, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; dur0 = '0; dur1 = '0; dur2 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_dur();
    test_abort();
    test_abort_at_zero();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
